// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
// Holds the controller state encoding and the iteration counter sizing rule.
package shift_add_multiplier_pkg;

  // 2'd3 is unused and is decoded as IDLE by the controller.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The counter must be able to hold the value BITS itself.
  function automatic int count_width(input int bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// Combinational BITS-wide unsigned adder with carry-out.
// Shared by the multiplier for one partial-product addition per clock.
module shift_add_multiplier_adder #(
  parameter int BITS = 4
) (
  input  logic [BITS-1:0] i_augend,
  input  logic [BITS-1:0] i_addend,
  output logic [BITS-1:0] o_sum,
  output logic            o_carry
);

  assign {o_carry, o_sum} = {1'b0, i_augend} + {1'b0, i_addend};

endmodule

// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned multiplier: one adder pass and a right shift per clock.
// Start/busy/done handshake; the product is held until the next accepted start.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [BITS-1:0]   i_multiplicand,
  input  logic [BITS-1:0]   i_multiplier,
  output logic              o_busy,
  output logic              o_done,
  output logic [2*BITS-1:0] o_product
);

  localparam int CW = count_width(BITS);
  localparam logic [CW-1:0] COUNT_INIT = CW'(BITS);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  state_t              r_state;
  state_t              w_next_state;
  logic                w_accept;
  logic [BITS-1:0]     r_mcand;
  logic [BITS-1:0]     r_acc;
  logic [BITS-1:0]     r_low;
  logic [CW-1:0]       r_count;
  logic [BITS-1:0]     w_addend;
  logic [BITS-1:0]     w_sum;
  logic                w_carry;
  logic [2*BITS-1:0]   w_shifted;

  assign w_addend = r_low[0] ? r_mcand : '0;

  shift_add_multiplier_adder #(.BITS(BITS)) u_adder (
    .i_augend (r_acc),
    .i_addend (w_addend),
    .o_sum    (w_sum),
    .o_carry  (w_carry)
  );

  // The carry becomes the new top bit of acc; it is consumed here, never stored.
  assign w_shifted = (2*BITS)'({w_carry, w_sum, r_low} >> 1);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch inferred.
    w_next_state = ST_IDLE;
    w_accept     = 1'b0;
    case (r_state)
      ST_RUN:  w_next_state = (r_count == COUNT_ONE) ? ST_DONE : ST_RUN;
      ST_DONE: w_next_state = ST_IDLE;
      default: begin
        w_accept     = i_start;
        w_next_state = i_start ? ST_RUN : ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!i_reset_n) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_low   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_mcand <= i_multiplicand;
      r_low   <= i_multiplier;
      r_acc   <= '0;
      r_count <= COUNT_INIT;
    end else if (r_state == ST_RUN) begin
      r_acc   <= w_shifted[2*BITS-1:BITS];
      r_low   <= w_shifted[BITS-1:0];
      r_count <= r_count - COUNT_ONE;
    end
  end

  assign o_busy    = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign o_done    = (r_state == ST_DONE);
  assign o_product = {r_acc, r_low};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier at BITS = 1, 4 and 8.
// Expected products and timing come from plain arithmetic, not the RTL's structure.
module tb_shift_add_multiplier;

  logic       clk;
  logic       rst_n;
  logic       start1, start4, start8;
  logic [0:0] a1, b1;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic       busy1, busy4, busy8;
  logic       done1, done4, done8;
  logic [1:0]  prod1;
  logic [7:0]  prod4;
  logic [15:0] prod8;

  int n_checks = 0;
  int n_fail   = 0;

  shift_add_multiplier #(.BITS(1)) u_dut1 (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start1),
    .i_multiplicand(a1), .i_multiplier(b1),
    .o_busy(busy1), .o_done(done1), .o_product(prod1)
  );
  shift_add_multiplier #(.BITS(4)) u_dut4 (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start4),
    .i_multiplicand(a4), .i_multiplier(b4),
    .o_busy(busy4), .o_done(done4), .o_product(prod4)
  );
  shift_add_multiplier #(.BITS(8)) u_dut8 (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start8),
    .i_multiplicand(a8), .i_multiplier(b8),
    .o_busy(busy8), .o_done(done8), .o_product(prod8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic logic get_busy(input int w);
    case (w)
      1:       return busy1;
      8:       return busy8;
      default: return busy4;
    endcase
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      1:       return done1;
      8:       return done8;
      default: return done4;
    endcase
  endfunction

  function automatic logic [63:0] get_prod(input int w);
    case (w)
      1:       return 64'(prod1);
      8:       return 64'(prod8);
      default: return 64'(prod4);
    endcase
  endfunction

  task automatic drive(input int w, input logic s, input logic [7:0] a, input logic [7:0] b);
    case (w)
      1:       begin start1 = s; a1 = a[0];   b1 = b[0];   end
      8:       begin start8 = s; a8 = a;      b8 = b;      end
      default: begin start4 = s; a4 = a[3:0]; b4 = b[3:0]; end
    endcase
  endtask

  // Called at a negedge with the selected DUT idle; returns at the negedge after DONE.
  task automatic run_mul(input int w, input logic [7:0] a, input logic [7:0] b, input string tag);
    logic [7:0]  mask;
    logic [63:0] expected;
    int          lat;
    bit          seen;
    mask     = 8'((1 << w) - 1);
    expected = 64'(a & mask) * 64'(b & mask);
    drive(w, 1'b1, a, b);
    @(negedge clk);
    drive(w, 1'b0, 8'($urandom), 8'($urandom));
    check({tag, "_busy_run"}, 64'(get_busy(w)), 64'd1);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 4 * w + 8) begin
      @(negedge clk);
      lat++;
      if (get_done(w)) seen = 1;
    end
    check({tag, "_latency"}, 64'(lat), 64'(w));
    check({tag, "_product"}, get_prod(w), expected);
    @(negedge clk);
    check({tag, "_idle"}, 64'({get_busy(w), get_done(w)}), 64'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          n_done;
    int          lat;
    int          cyc;
    int          exp_q[$];
    int          obs_q[$];
    logic [7:0]  ra, rb;

    rst_n = 1'b0;
    drive(1, 1'b0, 8'd0, 8'd0);
    drive(4, 1'b0, 8'd0, 8'd0);
    drive(8, 1'b0, 8'd0, 8'd0);
    #12;
    check("reset_w1", 64'({busy1, done1, prod1}), 64'd0);
    check("reset_w4", 64'({busy4, done4, prod4}), 64'd0);
    check("reset_w8", 64'({busy8, done8, prod8}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_mul(4, 8'd13, 8'd11, "m13x11");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("m13x11_hold", get_prod(4), 64'd143);
      check("m13x11_nodone", 64'({busy4, done4}), 64'd0);
    end

    run_mul(4, 8'd15, 8'd15, "m15x15");
    run_mul(4, 8'd0,  8'd0,  "m0x0");
    run_mul(4, 8'd0,  8'd15, "m0x15");
    run_mul(4, 8'd15, 8'd0,  "m15x0");

    // start/operand activity during RUN and DONE must be ignored
    drive(4, 1'b1, 8'd7, 8'd9);
    @(negedge clk);
    drive(4, 1'b1, 8'd2, 8'd2);
    lat = 0;
    while (!done4 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!done4) drive(4, 1'b1, 8'($urandom), 8'($urandom));
    end
    check("interf_latency", 64'(lat), 64'd4);
    @(negedge clk);
    drive(4, 1'b0, 8'd2, 8'd2);
    check("interf_busy_low", 64'(busy4), 64'd0);
    check("interf_product", 64'(prod4), 64'd63);
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done4 || busy4) n_done++;
    end
    check("interf_no_second_op", 64'(n_done), 64'd0);
    check("interf_product_held", 64'(prod4), 64'd63);

    // asynchronous reset between E2 and E3
    drive(4, 1'b1, 8'd12, 8'd12);
    @(negedge clk);
    drive(4, 1'b0, 8'd0, 8'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_busy", 64'(busy4), 64'd0);
    check("areset_done", 64'(done4), 64'd0);
    check("areset_product", 64'(prod4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_mul(4, 8'd3, 8'd5, "m3x5_after_reset");

    // i_start held high: an accept every BITS+2 edges
    for (int e = 0; e < 20; e += 6) if (e + 4 < 20) exp_q.push_back(e + 4);
    drive(4, 1'b1, 8'd6, 8'd6);
    for (cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (done4) begin
        obs_q.push_back(cyc);
        check("held_product", 64'(prod4), 64'd36);
      end
    end
    drive(4, 1'b0, 8'd0, 8'd0);
    check("held_pulse_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check("held_pulse_time", 64'(obs_q[i]), 64'(exp_q[i]));
    lat = 0;
    while (busy4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("held_drain_idle", 64'(busy4), 64'd0);
    check("held_drain_product", 64'(prod4), 64'd36);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        run_mul(4, 8'(x), 8'(y), "sweep4");

    for (int x = 0; x < 2; x++)
      for (int y = 0; y < 2; y++)
        run_mul(1, 8'(x), 8'(y), "sweep1");

    run_mul(8, 8'd255, 8'd255, "m8_max");
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_mul(8, ra, rb, "rand8");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
